// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the Ethernet transmit sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package eth_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_ABORT,
    ST_GAP
  } state_t;

  localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
  localparam logic [7:0]  ETH_SFD      = 8'hD5;
  localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_POLY     = 32'h04C11DB7;
  // Remainder left in a (non-reflected) CRC register after a good frame plus its FCS.
  localparam logic [31:0] CRC_RESIDUE  = 32'hC704DD7B;

  function automatic logic [31:0] bit_rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // The CRC register is kept in LSB-first (reflected) form, so byte idx of the
  // complemented register is exactly the idx-th FCS byte on the wire.
  function automatic logic [7:0] fcs_byte(input logic [31:0] c, input logic [1:0] idx);
    return ~c[8*idx +: 8];
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Byte-wide IEEE CRC-32 (poly 0x04C11DB7, data_in[0] first), reflected register.
// Latency: crc updates one cycle after en; crc_next is the combinational look-ahead.
// Backpressure: none; caller gates en. init has priority over en.
// Ports: clk, rst (async high) | init, en, data_in[7:0] | crc[31:0], crc_next[31:0]
module eth_crc32_d8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data_in,
  output logic [31:0] crc,
  output logic [31:0] crc_next
);
  import eth_tx_pkg::*;

  // Holding the register bit-reversed lets each data bit enter at bit 0 and
  // shift right, which is the LSB-first wire order.
  localparam logic [31:0] POLY_REFL = bit_rev32(CRC_POLY);

  always_comb begin
    crc_next = crc;
    for (int i = 0; i < 8; i++) begin
      crc_next = {1'b0, crc_next[31:1]} ^ ({32{crc_next[0] ^ data_in[i]}} & POLY_REFL);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       crc <= CRC_INIT;
    else if (init) crc <= CRC_INIT;
    else if (en)   crc <= crc_next;
  end

endmodule

// File: rtl/eth_tx_frame_ctrl.sv
// Ethernet MAC TX sequencer: preamble, SFD, payload, pad, FCS, inter-frame gap.
// Latency: tx_* registered; first payload byte on tx_data the cycle after its accept.
// Backpressure: s_ready only in SFD/DATA; a missing byte there aborts the frame.
// Ports: clk, rst (async high) | s_data, s_valid, s_last, s_ready |
//        tx_data, tx_en, tx_er | busy, frame_done, frame_err
module eth_tx_frame_ctrl #(
  parameter int MIN_PAYLOAD  = 60,
  parameter int MAX_PAYLOAD  = 1514,
  parameter int IFG          = 12,
  parameter int PREAMBLE_LEN = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] tx_data,
  output logic       tx_en,
  output logic       tx_er,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_err
);
  import eth_tx_pkg::*;

  state_t      state, state_nxt;
  logic [10:0] byte_cnt, byte_cnt_nxt;
  logic [15:0] phase_cnt, phase_cnt_nxt;
  logic        shown_last, shown_last_nxt;
  logic [7:0]  tx_data_nxt;
  logic        tx_en_nxt, tx_er_nxt, done_nxt, err_nxt;
  logic        accept;
  logic        crc_init, crc_en;
  logic [31:0] crc, crc_next;

  // The engine eats the byte currently on the wire, so it sees payload and pad
  // in order; the first FCS byte therefore comes from the look-ahead value.
  eth_crc32_d8 u_crc (
    .clk      (clk),
    .rst      (rst),
    .init     (crc_init),
    .en       (crc_en),
    .data_in  (tx_data),
    .crc      (crc),
    .crc_next (crc_next)
  );

  assign s_ready  = (state == ST_SFD) || ((state == ST_DATA) && !shown_last);
  assign accept   = s_valid && s_ready;
  assign busy     = (state != ST_IDLE);
  assign crc_init = (state == ST_SFD);
  assign crc_en   = (state == ST_DATA) || (state == ST_PAD);

  always_comb begin
    state_nxt      = state;
    byte_cnt_nxt   = byte_cnt;
    phase_cnt_nxt  = phase_cnt;
    shown_last_nxt = shown_last;
    tx_data_nxt    = 8'h00;
    tx_en_nxt      = 1'b0;
    tx_er_nxt      = 1'b0;
    done_nxt       = 1'b0;
    err_nxt        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s_valid) begin
          state_nxt     = ST_PRE;
          phase_cnt_nxt = '0;
          tx_data_nxt   = ETH_PREAMBLE;
          tx_en_nxt     = 1'b1;
        end
      end
      ST_PRE: begin
        tx_en_nxt = 1'b1;
        if (phase_cnt == 16'(PREAMBLE_LEN - 1)) begin
          state_nxt   = ST_SFD;
          tx_data_nxt = ETH_SFD;
        end else begin
          phase_cnt_nxt = phase_cnt + 16'd1;
          tx_data_nxt   = ETH_PREAMBLE;
        end
      end
      ST_SFD: begin
        tx_en_nxt = 1'b1;
        if (accept) begin
          state_nxt      = ST_DATA;
          tx_data_nxt    = s_data;
          byte_cnt_nxt   = 11'd1;
          shown_last_nxt = s_last;
        end else begin
          state_nxt = ST_ABORT;
          tx_er_nxt = 1'b1;
        end
      end
      ST_DATA: begin
        tx_en_nxt = 1'b1;
        if (shown_last) begin
          if (int'(byte_cnt) < MIN_PAYLOAD) begin
            state_nxt    = ST_PAD;
            byte_cnt_nxt = byte_cnt + 11'd1;
          end else begin
            state_nxt     = ST_FCS;
            phase_cnt_nxt = '0;
            tx_data_nxt   = fcs_byte(crc_next, 2'd0);
          end
        end else if (!s_valid || int'(byte_cnt) >= MAX_PAYLOAD) begin
          // Underrun, or an accept that would overrun the maximum: the
          // oversize byte is taken off the stream but never transmitted.
          state_nxt = ST_ABORT;
          tx_er_nxt = 1'b1;
        end else begin
          tx_data_nxt    = s_data;
          byte_cnt_nxt   = byte_cnt + 11'd1;
          shown_last_nxt = s_last;
        end
      end
      ST_PAD: begin
        tx_en_nxt = 1'b1;
        if (int'(byte_cnt) < MIN_PAYLOAD) begin
          byte_cnt_nxt = byte_cnt + 11'd1;
        end else begin
          state_nxt     = ST_FCS;
          phase_cnt_nxt = '0;
          tx_data_nxt   = fcs_byte(crc_next, 2'd0);
        end
      end
      ST_FCS: begin
        if (phase_cnt == 16'd3) begin
          state_nxt     = ST_GAP;
          phase_cnt_nxt = '0;
          done_nxt      = 1'b1;
        end else begin
          tx_en_nxt     = 1'b1;
          phase_cnt_nxt = phase_cnt + 16'd1;
          tx_data_nxt   = fcs_byte(crc, phase_cnt[1:0] + 2'd1);
        end
      end
      ST_ABORT: begin
        state_nxt     = ST_GAP;
        phase_cnt_nxt = '0;
        done_nxt      = 1'b1;
        err_nxt       = 1'b1;
      end
      ST_GAP: begin
        if (phase_cnt == 16'(IFG - 1)) begin
          if (s_valid) begin
            state_nxt     = ST_PRE;
            phase_cnt_nxt = '0;
            tx_data_nxt   = ETH_PREAMBLE;
            tx_en_nxt     = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          phase_cnt_nxt = phase_cnt + 16'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      byte_cnt   <= '0;
      phase_cnt  <= '0;
      shown_last <= 1'b0;
      tx_data    <= 8'h00;
      tx_en      <= 1'b0;
      tx_er      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      byte_cnt   <= byte_cnt_nxt;
      phase_cnt  <= phase_cnt_nxt;
      shown_last <= shown_last_nxt;
      tx_data    <= tx_data_nxt;
      tx_en      <= tx_en_nxt;
      tx_er      <= tx_er_nxt;
      frame_done <= done_nxt;
      frame_err  <= err_nxt;
    end
  end

endmodule

// File: doc/eth_tx_frame_ctrl.md
Name: eth_tx_frame_ctrl

Overview:
Ethernet MAC transmit sequencer. It accepts a payload byte stream (DA through end of data) from a requester over a valid/ready handshake and emits a GMII-style byte stream: preamble, SFD, payload, zero padding to minimum length, and the 4-byte FCS. It owns the byte-wide CRC-32 engine: it clears the engine per frame, enables it only on payload and pad bytes, and serialises the complemented result. It also enforces the inter-frame gap and aborts frames on underrun or oversize.

Parameters:
MIN_PAYLOAD, 60, minimum bytes before FCS (DA..pad); 0 disables padding
MAX_PAYLOAD, 1514, maximum payload bytes; exceeding this aborts the frame
IFG, 12, idle cycles (tx_en=0) enforced after each frame, min 1
PREAMBLE_LEN, 7, count of 0x55 bytes before SFD

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
s_data  in  8  payload byte
s_valid  in  1  payload byte valid
s_last  in  1  marks final payload byte (qualified by s_valid)
s_ready  out  1  byte accepted when s_valid&s_ready
tx_data  out  8  GMII TXD, registered
tx_en  out  1  GMII TX_EN, registered
tx_er  out  1  GMII TX_ER, registered
busy  out  1  high in any state except IDLE
frame_done  out  1  one-cycle pulse after the last FCS byte or abort byte
frame_err  out  1  valid with frame_done; 1 = aborted (underrun/oversize)

Behaviour:
- Reset: state IDLE, tx_data=0x00, tx_en=0, tx_er=0, s_ready=0, busy=0, frame_done=0, frame_err=0, counters 0, CRC state all-ones. Reset mid-frame drops the frame immediately, with no FCS and no done pulse.
- States: IDLE, PRE, SFD, DATA, PAD, FCS, ABORT, GAP. Outputs are registered; the state names the byte currently on tx_data.
- IDLE: s_ready=0. s_valid=1 -> PRE next cycle. s_data is not consumed.
- PRE: PREAMBLE_LEN cycles with tx_data=0x55, tx_en=1 -> SFD.
- SFD: tx_data=0xD5. CRC cleared to all-ones. s_ready=1. On accept -> DATA, with the byte on tx_data next cycle.
- DATA: s_ready=1 unless the byte being shown was accepted with s_last. Each accepted byte feeds the CRC (crc_en) and increments the 11-bit count.
  - Last byte shown and count < MIN_PAYLOAD -> PAD; otherwise -> FCS.
  - s_ready=1 and s_valid=0 (underrun) -> ABORT.
  - Accept that would make count > MAX_PAYLOAD -> ABORT; the byte is consumed and discarded.
- PAD: tx_data=0x00, fed to CRC, until count = MIN_PAYLOAD -> FCS.
- FCS: 4 cycles. Bytes are the complement of the final CRC, ordered so the wire carries standard IEEE CRC-32 least-significant byte first. Last FCS byte -> GAP; frame_done=1, frame_err=0 the following cycle.
- ABORT: one cycle with tx_en=1, tx_er=1, tx_data=0x00 -> GAP; frame_done=1, frame_err=1 next cycle. The requester must flush the remainder of an aborted frame; the block does not drain it.
- GAP: tx_en=0 for exactly IFG cycles. If s_valid=1 in the final GAP cycle -> PRE, giving a back-to-back gap of exactly IFG; otherwise -> IDLE.
- tx_en high time for N-byte payload: PREAMBLE_LEN + 1 + max(N, MIN_PAYLOAD) + 4.
- s_last with N=1 is legal. s_valid held low in IDLE leaves the block idle indefinitely.

Decomposition:
- Package eth_tx_pkg: state enum; constants ETH_PREAMBLE=8'h55, ETH_SFD=8'hD5, CRC_INIT=32'hFFFFFFFF, CRC residue 32'hC704DD7B.
- Sub-module eth_crc32_d8: byte-wide CRC-32 with polynomial 0x04C11DB7, data_in[0] processed first, synchronous init input and enable. It sits beside the async-reset crc unit so that per-frame clears never drive an asynchronous reset from logic.

Test Plan:
- MIN_PAYLOAD=0, payload ASCII "123456789" -> tx stream 55x7, D5, 31..39, then 26 39 F4 CB; tx_en high 21 cycles; frame_done=1, frame_err=0.
- Defaults, 10-byte payload 0x01..0x0A -> 50 bytes 0x00 pad, FCS matches a model CRC over 60 bytes; tx_en high 72 cycles. The model CRC over payload+FCS must leave residue C704DD7B.
- Two frames with s_valid held high -> exactly 12 tx_en=0 cycles between frames; s_ready never high in PRE or GAP.
- s_valid dropped after byte 20 -> one cycle of tx_en=1, tx_er=1, then tx_en=0; frame_done=1, frame_err=1; next frame's FCS is correct, confirming the CRC re-init.
- 1515-byte payload with no s_last -> ABORT on the 1515th accept; frame_err=1.
- rst asserted during FCS byte 2 -> all outputs 0 immediately, no frame_done. The next frame after release is correct.
